// File: rtl/pool1_out_fifo.sv
// Purpose: output FIFO for pool1 blobs; stores {eop, data} words and replays them in order to the downstream consumer.
// Latency: a word written in cycle N appears on blob_dout in cycle N+2 at the earliest (registered pop stage).
// Backpressure: blob_din_rdy is registered and drops when fewer than RDY_MARGIN entries are free; writes while full are dropped and flagged.
// Optional feature: define POOL1_OUT_FIFO_LEN_CHECK_EN to build the blob-length checker driving len_err.
module pool1_out_fifo #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 16,
  parameter int RDY_MARGIN = 8,
  parameter int BLOB_WORDS = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     blob_din_en,
  input  logic                     blob_din_eop,
  input  logic [DATA_W-1:0]        blob_din,
  output logic                     blob_din_rdy,
  input  logic                     blob_dout_rdy,
  output logic                     blob_dout_en,
  output logic                     blob_dout_eop,
  output logic [DATA_W-1:0]        blob_dout,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     ovf_err,
  output logic                     len_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL_LVL   = FW'(DEPTH);
  localparam logic [FW-1:0] MARGIN_LVL = FW'(RDY_MARGIN);

  // One storage entry: end-of-blob marker travels with its data word.
  typedef struct packed {
    logic              eop;
    logic [DATA_W-1:0] dat;
  } entry_t;

  entry_t          mem_q [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [FW-1:0]   free_d;
  logic            din_rdy_q, din_rdy_d;
  logic            ovf_q, ovf_d;
  logic            dout_vld_q;
  logic            dout_eop_q;
  logic [DATA_W-1:0] dout_dat_q;

  logic            pop_vld;
  logic            push_vld;
  logic            full;

  // Handshake decode: pop has priority over the full check so a write into a
  // full FIFO still lands when an entry is freed in the same cycle.
  always_comb begin
    full     = (fill_q == FULL_LVL);
    pop_vld  = blob_dout_rdy && (fill_q != '0);
    push_vld = blob_din_en && (!full || pop_vld);
    ovf_d    = ovf_q || (blob_din_en && !push_vld);
  end

  // Next-state for pointers, occupancy and the registered ready flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push_vld) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_vld) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_vld, pop_vld})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
    free_d    = FULL_LVL - fill_d;
    din_rdy_d = (free_d >= MARGIN_LVL);
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_vld) begin
      mem_q[wr_ptr_q] <= '{eop: blob_din_eop, dat: blob_din};
    end
  end

  // Control state: pointers, occupancy, ready and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      din_rdy_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      din_rdy_q <= din_rdy_d;
      ovf_q     <= ovf_d;
    end
  end

  // Output stage: one-cycle valid pulse per pop; data/eop hold between pops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_vld_q <= 1'b0;
      dout_eop_q <= 1'b0;
      dout_dat_q <= '0;
    end else begin
      dout_vld_q <= pop_vld;
      if (pop_vld) begin
        dout_eop_q <= mem_q[rd_ptr_q].eop;
        dout_dat_q <= mem_q[rd_ptr_q].dat;
      end
    end
  end

`ifdef POOL1_OUT_FIFO_LEN_CHECK_EN
  localparam int CW = $clog2(BLOB_WORDS + 1);
  localparam logic [CW-1:0] BLOB_LVL = CW'(BLOB_WORDS);

  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [CW-1:0] word_cnt_inc;
  logic          len_err_q, len_err_d;

  // Blob-length check on accepted words: eop must land exactly on the last
  // word, and reaching the full length without eop is also an error.
  always_comb begin
    word_cnt_inc = word_cnt_q + CW'(1);
    word_cnt_d   = word_cnt_q;
    len_err_d    = len_err_q;
    if (push_vld) begin
      if (blob_din_eop) begin
        if (word_cnt_inc != BLOB_LVL) begin
          len_err_d = 1'b1;
        end
        word_cnt_d = '0;
      end else if (word_cnt_inc == BLOB_LVL) begin
        len_err_d  = 1'b1;
        word_cnt_d = '0;
      end else begin
        word_cnt_d = word_cnt_inc;
      end
    end
  end

  // Word counter and sticky length error register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

  assign blob_din_rdy  = din_rdy_q;
  assign blob_dout_en  = dout_vld_q;
  assign blob_dout_eop = dout_eop_q;
  assign blob_dout     = dout_dat_q;
  assign fill_level    = fill_q;
  assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_pool1_out_fifo.sv
// Directed bench for pool1_out_fifo with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-derived from the word generator w(i).
module tb_pool1_out_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        blob_din_en;
  logic        blob_din_eop;
  logic [63:0] blob_din;
  logic        blob_din_rdy;
  logic        blob_dout_rdy;
  logic        blob_dout_en;
  logic        blob_dout_eop;
  logic [63:0] blob_dout;
  logic [4:0]  fill_level;
  logic        ovf_err;
  logic        len_err;

  int vectors = 0;
  int errors  = 0;

  pool1_out_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .blob_din_en  (blob_din_en),
    .blob_din_eop (blob_din_eop),
    .blob_din     (blob_din),
    .blob_din_rdy (blob_din_rdy),
    .blob_dout_rdy(blob_dout_rdy),
    .blob_dout_en (blob_dout_en),
    .blob_dout_eop(blob_dout_eop),
    .blob_dout    (blob_dout),
    .fill_level   (fill_level),
    .ovf_err      (ovf_err),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] w(input int i);
    return {16'hB10B, 16'(i), 16'h5A5A, 16'(i)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst           = 1'b0;
    blob_din_en   = 1'b0;
    blob_din_eop  = 1'b0;
    blob_din      = '0;
    blob_dout_rdy = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic write_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      blob_din_en  = 1'b1;
      blob_din_eop = 1'b0;
      blob_din     = w(first + i);
      step();
    end
    blob_din_en = 1'b0;
  endtask

  task automatic drain(input string tag, input int n_exp, input int base, input int budget);
    int k;
    k = 0;
    for (int c = 0; c < budget; c++) begin
      if (blob_dout_en === 1'b1) begin
        check(tag, blob_dout, w(base + k));
        k++;
      end
      step();
    end
    check({tag, "_cnt"}, 64'(k), 64'(n_exp));
  endtask

  initial begin
    int k;
    int pulses;
    logic exp_len;

    // Reset state, held across a clock edge.
    rst           = 1'b0;
    blob_din_en   = 1'b0;
    blob_din_eop  = 1'b0;
    blob_din      = '0;
    blob_dout_rdy = 1'b0;
    #2;
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_din_rdy", 64'(blob_din_rdy), 64'd0);
    check("rst_dout_en", 64'(blob_dout_en), 64'd0);
    check("rst_dout", blob_dout, 64'd0);
    check("rst_ovf", 64'(ovf_err), 64'd0);
    check("rst_len", 64'(len_err), 64'd0);
    step();
    check("rst_din_rdy_held", 64'(blob_din_rdy), 64'd0);
    rst = 1'b1;
    step();
    check("rel_din_rdy", 64'(blob_din_rdy), 64'd1);

    // Full-length blob streamed back-to-back with downstream always ready.
    blob_dout_rdy = 1'b1;
    k = 0;
    for (int i = 0; i < 1030; i++) begin
      if (i < 1024) begin
        blob_din_en  = 1'b1;
        blob_din     = w(i);
        blob_din_eop = (i == 1023);
      end else begin
        blob_din_en  = 1'b0;
        blob_din_eop = 1'b0;
      end
      step();
      if (blob_dout_en === 1'b1) begin
        check("stream_dat", blob_dout, w(k));
        check("stream_eop", 64'(blob_dout_eop), 64'(k == 1023));
        k++;
      end
    end
    check("stream_cnt", 64'(k), 64'd1024);
    check("stream_ovf", 64'(ovf_err), 64'd0);
    check("stream_len", 64'(len_err), 64'd0);
    check("stream_hold_eop", 64'(blob_dout_eop), 64'd1);
    check("stream_hold_dat", blob_dout, w(1023));

    // Short blob: eop on word 1000.
    apply_reset();
    blob_dout_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      blob_din_en  = 1'b1;
      blob_din     = w(i);
      blob_din_eop = (i == 999);
      step();
    end
    blob_din_en  = 1'b0;
    blob_din_eop = 1'b0;
    step();
    step();
`ifdef POOL1_OUT_FIFO_LEN_CHECK_EN
    exp_len = 1'b1;
`else
    exp_len = 1'b0;
`endif
    check("short_len", 64'(len_err), 64'(exp_len));

    // Ready threshold: 8 free keeps ready, 7 free drops it, one pop restores it.
    apply_reset();
    write_words(0, 8);
    check("thr8_fill", 64'(fill_level), 64'd8);
    check("thr8_rdy", 64'(blob_din_rdy), 64'd1);
    write_words(8, 1);
    check("thr9_fill", 64'(fill_level), 64'd9);
    check("thr9_rdy", 64'(blob_din_rdy), 64'd0);
    blob_dout_rdy = 1'b1;
    step();
    blob_dout_rdy = 1'b0;
    check("thr_pop_fill", 64'(fill_level), 64'd8);
    check("thr_pop_rdy", 64'(blob_din_rdy), 64'd1);
    check("thr_pop_en", 64'(blob_dout_en), 64'd1);
    check("thr_pop_dat", blob_dout, w(0));
    step();
    check("thr_pulse_end", 64'(blob_dout_en), 64'd0);
    check("thr_hold_dat", blob_dout, w(0));

    // Overflow: 17 writes into a blocked FIFO; the 17th is dropped.
    apply_reset();
    write_words(0, 17);
    check("ovf_fill", 64'(fill_level), 64'd16);
    check("ovf_flag", 64'(ovf_err), 64'd1);
    check("ovf_rdy", 64'(blob_din_rdy), 64'd0);
    blob_dout_rdy = 1'b1;
    drain("ovf_drain", 16, 0, 25);
    check("ovf_empty", 64'(fill_level), 64'd0);
    check("ovf_sticky", 64'(ovf_err), 64'd1);

    // Full FIFO with simultaneous write and pop.
    apply_reset();
    write_words(0, 16);
    check("full_fill", 64'(fill_level), 64'd16);
    blob_din_en   = 1'b1;
    blob_din      = w(16);
    blob_dout_rdy = 1'b1;
    step();
    blob_din_en = 1'b0;
    check("sim_fill", 64'(fill_level), 64'd16);
    check("sim_ovf", 64'(ovf_err), 64'd0);
    drain("sim_drain", 17, 0, 30);
    check("sim_empty", 64'(fill_level), 64'd0);

    // Mid-blob reset with 5 words stored and an output pulse in flight.
    apply_reset();
    write_words(0, 5);
    check("mid_fill", 64'(fill_level), 64'd5);
    blob_dout_rdy = 1'b1;
    step();
    check("mid_en", 64'(blob_dout_en), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_fill", 64'(fill_level), 64'd0);
    check("mid_rst_en", 64'(blob_dout_en), 64'd0);
    check("mid_rst_dout", blob_dout, 64'd0);
    step();
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (blob_dout_en === 1'b1) pulses++;
    end
    check("mid_no_stale", 64'(pulses), 64'd0);
    check("mid_rel_rdy", 64'(blob_din_rdy), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
